// File: rtl/uart_mmio_ctrl_pkg.sv
// Shared definitions for the UART MMIO sequencer: TX FSM encoding, the
// empty-read value, status word bit positions and the decoded addresses.
package uart_mmio_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2
    } tx_state_t;

    localparam logic [31:0] UART_EMPTY_READ = 32'hFFFF_FFFF;

    // Bit positions inside the status word (only built with UART_STATUS_REG_EN)
    localparam int STAT_RX_EMPTY   = 0;
    localparam int STAT_RX_FULL    = 1;
    localparam int STAT_TX_EMPTY   = 2;
    localparam int STAT_TX_FULL    = 3;
    localparam int STAT_RX_OVERRUN = 4;

    localparam logic [31:0] UART_TX_ADDR = 32'h0000_0400;
    localparam logic [31:0] UART_RX_ADDR = 32'h0000_0404;

endpackage

// File: rtl/uart_mmio_ctrl_if.sv
// Bundle of the core-side strobes and the TX/RX serial engine handshake.
// The controller uses the slave modport; the core/engines side uses master.
interface uart_mmio_ctrl_if;
    logic        uart_write_en;
    logic        uart_read_en;
    logic        status_rd_en;
    logic [7:0]  wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic        rx_valid;
    logic [7:0]  rx_data;

    modport master (
        output uart_write_en, uart_read_en, status_rd_en, wdata,
        output tx_busy, rx_valid, rx_data,
        input  rdata, stall, tx_start, tx_data
    );

    modport slave (
        input  uart_write_en, uart_read_en, status_rd_en, wdata,
        input  tx_busy, rx_valid, rx_data,
        output rdata, stall, tx_start, tx_data
    );
endinterface

// File: rtl/uart_mmio_ctrl_sync_byte_fifo.sv
// Single-clock byte FIFO with a combinational head output. Pointers carry one
// extra wrap bit so full and empty are told apart without a counter.
module sync_byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_reg;
    logic [AW:0] rd_ptr_reg;
    logic [7:0]  mem [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign empty   = (wr_ptr_reg == rd_ptr_reg);
    assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                     (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    // A pop on a full FIFO frees the slot the same-cycle push lands in.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr_reg[AW-1:0]];

    // Pointer update; both wrap naturally through the extra MSB.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
        end
    end

    // Storage write; contents need no reset since the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg[AW-1:0]] <= din;
    end
endmodule

// File: rtl/uart_mmio_ctrl.sv
// UART MMIO sequencer: buffers core stores into a TX FIFO drained by a
// start/busy FSM, collects received bytes in an RX FIFO for word reads, and
// stalls the core when a store would overflow the TX FIFO.
// Optional build macro UART_STATUS_REG_EN adds the status word read and the
// sticky rx_overrun flag.
module uart_mmio_ctrl #(
    parameter int TX_DEPTH = 16,
    parameter int RX_DEPTH = 16
) (
    input logic              clk,
    input logic              reset,
    uart_mmio_ctrl_if.slave  bus
);
    import uart_mmio_pkg::*;

    tx_state_t  state_reg;
    tx_state_t  state_next;
    logic       tx_start_reg;
    logic [7:0] tx_data_reg;

    logic       tx_pop;
    logic       tx_full;
    logic       tx_empty;
    logic [7:0] tx_head;

    logic       rx_pop;
    logic       rx_full;
    logic       rx_empty;
    logic [7:0] rx_head;

    sync_byte_fifo #(.DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (bus.uart_write_en),
        .pop   (tx_pop),
        .din   (bus.wdata),
        .dout  (tx_head),
        .full  (tx_full),
        .empty (tx_empty)
    );

    sync_byte_fifo #(.DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (bus.rx_valid),
        .pop   (rx_pop),
        .din   (bus.rx_data),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

    // A store only stalls when the FIFO is full and the FSM is not freeing a slot.
    assign bus.stall    = bus.uart_write_en && tx_full && !tx_pop;
    assign bus.tx_start = tx_start_reg;
    assign bus.tx_data  = tx_data_reg;
    assign rx_pop       = bus.uart_read_en && !rx_empty;

    // TX FSM next state: launch from IDLE, then follow the transmitter's busy.
    always_comb begin
        state_next = state_reg;
        tx_pop     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!tx_empty && !bus.tx_busy) begin
                    tx_pop     = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (bus.tx_busy) state_next = BUSY;
            end
            BUSY: begin
                if (!bus.tx_busy) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // TX FSM state, launch pulse and held transmit byte.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= IDLE;
            tx_start_reg <= 1'b0;
            tx_data_reg  <= 8'h00;
        end else begin
            state_reg    <= state_next;
            tx_start_reg <= tx_pop;
            if (tx_pop) tx_data_reg <= tx_head;
        end
    end

`ifdef UART_STATUS_REG_EN
    logic rx_overrun_reg;

    // Sticky overrun: set on a dropped byte, cleared by a data read; a drop wins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_overrun_reg <= 1'b0;
        end else if (bus.rx_valid && rx_full && !rx_pop) begin
            rx_overrun_reg <= 1'b1;
        end else if (bus.uart_read_en) begin
            rx_overrun_reg <= 1'b0;
        end
    end
`else
    logic unused_status;
    assign unused_status = bus.status_rd_en ^ rx_full;
`endif

    // Read data mux: RX head on a data read, status word when enabled, else all-ones.
    always_comb begin
        bus.rdata = UART_EMPTY_READ;
        if (bus.uart_read_en) begin
            if (!rx_empty) bus.rdata = {24'h0, rx_head};
        end
`ifdef UART_STATUS_REG_EN
        else if (bus.status_rd_en) begin
            bus.rdata                  = 32'h0;
            bus.rdata[STAT_RX_EMPTY]   = rx_empty;
            bus.rdata[STAT_RX_FULL]    = rx_full;
            bus.rdata[STAT_TX_EMPTY]   = tx_empty;
            bus.rdata[STAT_TX_FULL]    = tx_full;
            bus.rdata[STAT_RX_OVERRUN] = rx_overrun_reg;
        end
`endif
    end
endmodule

// File: doc/uart_mmio_ctrl.md
Name: uart_mmio_ctrl

Overview:
Sequencer between the core's decoded UART strobes (write-byte at 0x400, read-word at 0x404) and the UART TX/RX serial engines. It buffers outgoing bytes in a TX FIFO and drains them into the transmitter with a start/busy handshake. It collects incoming bytes in an RX FIFO and serves single-cycle reads. It stalls the single-cycle core when a store would overflow the TX FIFO.

Parameters:
TX_DEPTH, 16, TX FIFO entries; power of two, >= 2.
RX_DEPTH, 16, RX FIFO entries; power of two, >= 2.

Ports:
clk  in  1  system clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-low reset; the polarity and synchronicity are fixed.
uart_write_en  in  1  SB to 0x400 decoded this cycle.
uart_read_en  in  1  LW from 0x404 decoded this cycle.
status_rd_en  in  1  status read strobe; used only with the optional feature.
wdata  in  8  byte to transmit, taken from rs2[7:0].
rdata  out  32  read data returned to the result mux.
stall  out  1  holds the PC and suppresses register writeback this cycle.
tx_start  out  1  one-cycle pulse telling the transmitter to load tx_data.
tx_data  out  8  byte presented to the transmitter.
tx_busy  in  1  transmitter is shifting a frame.
rx_valid  in  1  one-cycle pulse: rx_data holds a received byte.
rx_data  in  8  received byte.

Behaviour:
- Reset (reset=0, asynchronous): both FIFOs are empty, the TX FSM is in IDLE, rx_overrun=0, tx_start=0, tx_data=0, stall=0, rdata=32'hFFFF_FFFF.
- TX push: uart_write_en and TX FIFO not full pushes wdata at the clock edge; stall=0.
  - Full and no pop this cycle: stall=1 combinationally and nothing is pushed. The core re-issues the store next cycle.
  - Full with a pop this cycle: the push is accepted and stall=0.
- TX FSM states:
  - IDLE: if the FIFO is not empty and tx_busy=0, pop the head, register it into tx_data, pulse tx_start for one cycle, go to START.
  - START: wait for tx_busy=1, then go to BUSY.
  - BUSY: wait for tx_busy=0, then go to IDLE.
  - Minimum spacing between tx_start pulses is 3 cycles. tx_data holds its value until the next launch.
- RX push: rx_valid pushes rx_data. If the FIFO is full with no pop this cycle, the byte is dropped and rx_overrun is set (sticky).
  - Full with a simultaneous pop: the push is accepted.
- RX read: rdata is combinational.
  - uart_read_en and FIFO not empty: rdata = {24'h0, head}; the head is popped at the edge.
  - uart_read_en and FIFO empty: rdata = 32'hFFFF_FFFF; no pop.
  - The read also clears rx_overrun at the edge; a simultaneous overrun event wins.
- Empty with a simultaneous push and read: the read returns 0xFFFFFFFF and the byte is retained.
- Pointers: each FIFO uses log2(DEPTH)+1 bit pointers that wrap naturally. Full/empty come from comparing the MSB and the remaining bits.
- uart_write_en and uart_read_en are never both asserted (one instruction per cycle). If they are, each side is handled independently.
- reset deasserted mid-frame: the FSM returns to IDLE. The transmitter is reset by the same reset.

Optional Feature:
UART_STATUS_REG_EN:
- Defined: status_rd_en makes rdata = {27'h0, rx_overrun, tx_full, tx_empty, rx_full, rx_empty} (bits 4..0) with no pop. If uart_read_en is also asserted, uart_read_en has priority.
- Undefined: status_rd_en is ignored, and the rx_overrun flop and its logic are absent. Dropped bytes are silently discarded.

Decomposition:
- Package uart_mmio_pkg holds:
  - TX FSM state encoding: IDLE=2'd0, START=2'd1, BUSY=2'd2.
  - UART_EMPTY_READ = 32'hFFFF_FFFF.
  - Status bit indices.
  - UART_TX_ADDR = 32'h400 and UART_RX_ADDR = 32'h404.
- Sub-module sync_byte_fifo (parameter DEPTH) is instantiated twice, once for TX and once for RX. It exposes push, pop, din, dout (head, combinational), full, empty.

Test Plan:
- Reset, then write 8'h41 with tx_busy low → tx_start pulses 1 cycle later with tx_data=8'h41. The FSM passes START→BUSY as tx_busy rises and returns to IDLE when it falls.
- Hold tx_busy=1 and issue 17 writes, 8'h00..8'h10 (TX_DEPTH=16) → stall=0 for 16 writes and stall=1 on the 17th. Release tx_busy → byte 8'h10 is accepted on retry, and transmit order is 00..10.
- Pulse rx_valid with 8'h5A then 8'hA5, then two reads → rdata=32'h0000005A then 32'h000000A5. A third read → 32'hFFFF_FFFF.
- Push 17 RX bytes with no reads, then read all → the first 16 bytes are returned intact. With UART_STATUS_REG_EN, status bit 4 is 1 before the first read and 0 after it.
- RX FIFO full, rx_valid and uart_read_en in the same cycle → the head is returned, the new byte is stored at the tail, and rx_overrun stays 0.
- Assert reset mid-frame in BUSY with 5 bytes queued → all outputs return to reset values immediately, and nothing is transmitted after release.
